issue_alu_queue: RTL and testbench
==================================

Name: issue_alu_queue

Overview:
Per-ALU-unit buffer between the issue stage and execute_alu; one instance per ALU unit (ALU_UNIT_NUM instances).
- Accepts issue_execute_pack_t entries from issue.
- Presents the oldest entry combinationally to execute_alu through the data_out / data_out_valid / pop handshake.
- Discards all contents on a commit flush.
- Reports occupancy so issue can stop sending when full.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
PTR_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
issue_alu_fifo_data_in  input  issue_execute_pack_t  entry from issue
issue_alu_fifo_push  input  1  write request
issue_alu_fifo_full  output  1  no free entry
issue_alu_fifo_free_space  output  PTR_W+1  free entries, 0..DEPTH
issue_alu_fifo_data_out  output  issue_execute_pack_t  oldest entry, to execute_alu
issue_alu_fifo_data_out_valid  output  1  data_out holds a real entry
issue_alu_fifo_pop  input  1  execute_alu consumed data_out this cycle
commit_feedback_pack  input  commit_feedback_pack_t  uses .enable and .flush only

Behaviour:
- Storage: DEPTH-entry array plus rptr and wptr, each PTR_W+1 bits; the MSB is the wrap bit.
  - empty = (rptr == wptr).
  - full = index bits equal and wrap bits differ.
- Reset (rst=0, asynchronous): rptr=wptr=0, so full=0, free_space=DEPTH, data_out_valid=0. Array contents are don't-care and are not reset.
- flush_req = commit_feedback_pack.enable & commit_feedback_pack.flush.
- Priority each cycle: flush_req > pop/push.
  - On flush_req: rptr<=0, wptr<=0; push and pop in the same cycle are ignored.
- Push accepted iff push & !full & !flush_req.
  - The entry is written at wptr[PTR_W-1:0]; wptr increments.
  - Push while full is dropped silently; issue must not do this, and the bench checks contents are unaffected.
- Pop accepted iff pop & !empty & !flush_req; rptr increments. Pop while empty is a no-op.
- Push and pop in the same cycle:
  - Both accepted independently under the rules above; occupancy is unchanged.
  - When full, the push is still rejected. full is a state flag with no same-cycle pop credit.
  - When empty, the push is accepted and the pop ignored. There is no bypass: the new entry appears at data_out the next cycle.
- Outputs are combinational from registered state only, with no path from any input:
  - data_out = array[rptr index]; data_out_valid = !empty.
  - When empty, data_out is don't-care.
- free_space = DEPTH - (wptr - rptr), computed at PTR_W+1 bits with modular subtraction.
- Latency: an entry pushed in cycle N is visible at data_out in cycle N+1 if the queue was empty.
- Wrap-around: pointers wrap naturally mod 2*DEPTH; ordering is preserved across wraps.
- Reset mid-operation: state clears immediately on rst assertion, independent of clk; the first push after rst deasserts behaves as from empty.
- Entries are stored verbatim; no field (including .enable or .valid) is inspected or altered.

Decomposition:
- issue_execute_pack_t and commit_feedback_pack_t come from the shared common package; no new typedefs are added there.
- Sub-module fifo_ptr_ctrl (parameter DEPTH) handles pointer/flag/free_space logic.
  - Inputs: push, pop, flush.
  - Outputs: rptr, wptr, full, empty, free_space, push_accept, pop_accept.
  - The top level holds the storage array only.
  - It is reusable by the LSU, BRU, MUL, DIV and CSR queues.

Test Plan:
1. Reset, then three pushes with rob_id 5,6,7 and no pop -> data_out_valid=1 from the cycle after the first push; data_out.rob_id=5; free_space=1; full=0.
2. Fill DEPTH=4 (rob_id 1..4), then push rob_id 9 -> full=1, free_space=0; the push is dropped; subsequent pops return 1,2,3,4, then data_out_valid=0.
3. Empty queue, push rob_id 3 and pop in the same cycle -> data_out_valid=0 that cycle; next cycle data_out_valid=1, rob_id=3, free_space=3.
4. Eleven entries streamed with one push and one pop per cycle after a one-entry prime -> output order 0..10 is exact across two pointer wraps; free_space is constant at 3.
5. Two entries held, commit_feedback_pack enable=1, flush=1 together with push and pop -> next cycle data_out_valid=0, free_space=4; the pushed entry is not retained.
6. Two entries held, rst driven low between clock edges -> data_out_valid=0 and free_space=4 before the next rising edge.

Source files
------------

// File: rtl/issue_alu_queue_pkg.sv
// Shared issue/commit pack types and queue defaults used by the ALU issue queue.
// No latency or backpressure of its own; types only.
package issue_alu_queue_pkg;

    localparam int ROB_ID_W          = 7;
    localparam int ALU_QUEUE_DEPTH   = 4;

    typedef struct packed {
        logic                enable;
        logic                valid;
        logic [ROB_ID_W-1:0] rob_id;
        logic [3:0]          op;
        logic [4:0]          rd;
        logic [31:0]         src1;
        logic [31:0]         src2;
    } issue_execute_pack_t;

    typedef struct packed {
        logic                enable;
        logic                flush;
        logic [ROB_ID_W-1:0] commit_rob_id;
        logic [1:0]          commit_num;
    } commit_feedback_pack_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit read/write pointer control with full/empty/free-space flags.
// Flags are registered-state only; push/pop accept is combinational from the request.
// Push is refused while full (no same-cycle pop credit); flush overrides push and pop.
module fifo_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic           flush_i,
    output logic [PTR_W:0] rptr_o,
    output logic [PTR_W:0] wptr_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] free_space_o,
    output logic           push_accept_o,
    output logic           pop_accept_o
);

    localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);

    logic [PTR_W:0] rptr_q, rptr_d;
    logic [PTR_W:0] wptr_q, wptr_d;

    assign empty_o = (rptr_q == wptr_q);
    assign full_o  = (rptr_q[PTR_W-1:0] == wptr_q[PTR_W-1:0]) &&
                     (rptr_q[PTR_W] != wptr_q[PTR_W]);

    assign push_accept_o = push_i & ~full_o  & ~flush_i;
    assign pop_accept_o  = pop_i  & ~empty_o & ~flush_i;

    // Modular subtraction gives the occupancy correctly across pointer wraps.
    assign free_space_o = DEPTH_L - (wptr_q - rptr_q);

    assign rptr_o = rptr_q;
    assign wptr_o = wptr_q;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (pop_accept_o)  rptr_d = rptr_q + ONE;
            if (push_accept_o) wptr_d = wptr_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

endmodule

// File: rtl/issue_alu_queue.sv
// Per-ALU-unit issue queue: oldest entry shown combinationally to execute_alu.
// Push to data_out visible next cycle (no bypass); pop consumes head same cycle.
// Issue throttles on full/free_space; a commit flush empties the queue.
module issue_alu_queue
    import issue_alu_queue_pkg::*;
#(
    parameter  int DEPTH = ALU_QUEUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  issue_execute_pack_t   issue_alu_fifo_data_in,
    input  logic                  issue_alu_fifo_push,
    output logic                  issue_alu_fifo_full,
    output logic [PTR_W:0]        issue_alu_fifo_free_space,
    output issue_execute_pack_t   issue_alu_fifo_data_out,
    output logic                  issue_alu_fifo_data_out_valid,
    input  logic                  issue_alu_fifo_pop,
    input  commit_feedback_pack_t commit_feedback_pack
);

    logic [PTR_W:0] rptr;
    logic [PTR_W:0] wptr;
    logic           empty;
    logic           push_accept;
    logic           pop_accept;
    logic           flush_req;

    issue_execute_pack_t mem_q [DEPTH];

    assign flush_req = commit_feedback_pack.enable & commit_feedback_pack.flush;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk           (clk),
        .rst_n         (rst),
        .push_i        (issue_alu_fifo_push),
        .pop_i         (issue_alu_fifo_pop),
        .flush_i       (flush_req),
        .rptr_o        (rptr),
        .wptr_o        (wptr),
        .full_o        (issue_alu_fifo_full),
        .empty_o       (empty),
        .free_space_o  (issue_alu_fifo_free_space),
        .push_accept_o (push_accept),
        .pop_accept_o  (pop_accept)
    );

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem_q[wptr[PTR_W-1:0]] <= issue_alu_fifo_data_in;
        end
    end

    assign issue_alu_fifo_data_out       = mem_q[rptr[PTR_W-1:0]];
    assign issue_alu_fifo_data_out_valid = ~empty;

    logic unused_bits;
    assign unused_bits = ^{rptr[PTR_W], wptr[PTR_W], pop_accept,
                           commit_feedback_pack.commit_rob_id,
                           commit_feedback_pack.commit_num};

endmodule

// File: tb/tb_issue_alu_queue.sv
module tb_issue_alu_queue;
    import issue_alu_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  rst;
    issue_execute_pack_t   din;
    logic                  push;
    logic                  full;
    logic [PTR_W:0]        free;
    issue_execute_pack_t   dout;
    logic                  dvld;
    logic                  pop;
    commit_feedback_pack_t cfb;

    always #5 clk = ~clk;

    issue_alu_queue #(.DEPTH(DEPTH)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .issue_alu_fifo_data_in        (din),
        .issue_alu_fifo_push           (push),
        .issue_alu_fifo_full           (full),
        .issue_alu_fifo_free_space     (free),
        .issue_alu_fifo_data_out       (dout),
        .issue_alu_fifo_data_out_valid (dvld),
        .issue_alu_fifo_pop            (pop),
        .commit_feedback_pack          (cfb)
    );

    int tests = 0;
    int fails = 0;

    // Reference: the queue contents as an ordered list, oldest first.
    issue_execute_pack_t mq[$];

    typedef struct {
        logic       push;
        logic       pop;
        logic       flush;
        logic [6:0] rob;
        logic       evld;
        logic [6:0] erob;
        int         efree;
        logic       efull;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic pu, input logic po, input logic fl, input int rob,
                       input logic ev, input int er, input int ef, input logic efu);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.rob = 7'(rob);
        v.evld = ev; v.erob = 7'(er); v.efree = ef; v.efull = efu;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic issue_execute_pack_t mk(input logic [6:0] rob);
        issue_execute_pack_t p;
        p.enable = 1'($urandom);
        p.valid  = 1'($urandom);
        p.rob_id = rob;
        p.op     = 4'($urandom);
        p.rd     = 5'($urandom);
        p.src1   = $urandom;
        p.src2   = $urandom;
        return p;
    endfunction

    task automatic drive(input logic pu, input logic po, input logic en, input logic fl,
                         input logic [6:0] rob);
        din                = mk(rob);
        push               = pu;
        pop                = po;
        cfb.enable         = en;
        cfb.flush          = fl;
        cfb.commit_rob_id  = 7'($urandom);
        cfb.commit_num     = 2'($urandom);
    endtask

    task automatic model_edge();
        bit was_empty = (mq.size() == 0);
        bit was_full  = (mq.size() == DEPTH);
        if (cfb.enable && cfb.flush) begin
            mq.delete();
        end else begin
            if (pop && !was_empty) void'(mq.pop_front());
            if (push && !was_full) mq.push_back(din);
        end
    endtask

    task automatic model_chk(input string nm);
        chk({nm, " valid"}, 64'(dvld), 64'(mq.size() != 0));
        chk({nm, " full"},  64'(full), 64'(mq.size() == DEPTH));
        chk({nm, " free"},  64'(free), 64'(DEPTH - mq.size()));
        if (mq.size() != 0) begin
            tests++;
            if (dout !== mq[0]) begin
                fails++;
                $display("FAIL %s data: got %h expected %h", nm, dout, mq[0]);
            end
        end
    endtask

    task automatic cyc(input string nm);
        @(posedge clk);
        model_edge();
        #1;
        model_chk(nm);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Directed vectors: each row is applied for one cycle and checked after the edge.
        // Three pushes, then drain.
        add(1,0,0, 5, 1, 5, 3, 0);
        add(1,0,0, 6, 1, 5, 2, 0);
        add(1,0,0, 7, 1, 5, 1, 0);
        add(0,1,0, 0, 1, 6, 2, 0);
        add(0,1,0, 0, 1, 7, 3, 0);
        add(0,1,0, 0, 0, 0, 4, 0);
        // Fill, overfill, push+pop while full, drain.
        add(1,0,0, 1, 1, 1, 3, 0);
        add(1,0,0, 2, 1, 1, 2, 0);
        add(1,0,0, 3, 1, 1, 1, 0);
        add(1,0,0, 4, 1, 1, 0, 1);
        add(1,0,0, 9, 1, 1, 0, 1);
        add(1,1,0, 8, 1, 2, 1, 0);
        add(0,1,0, 0, 1, 3, 2, 0);
        add(0,1,0, 0, 1, 4, 3, 0);
        add(0,1,0, 0, 0, 0, 4, 0);
        // Push+pop on empty: no bypass.
        add(1,1,0, 3, 1, 3, 3, 0);
        add(0,1,0, 0, 0, 0, 4, 0);
        // Flush with concurrent push/pop.
        add(1,0,0,10, 1,10, 3, 0);
        add(1,0,0,11, 1,10, 2, 0);
        add(1,1,1,12, 0, 0, 4, 0);
        add(0,0,0, 0, 0, 0, 4, 0);
        add(1,0,0,13, 1,13, 3, 0);
        add(0,1,0, 0, 0, 0, 4, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 64'(dvld), 64'd0);
        chk("reset full",  64'(full), 64'd0);
        chk("reset free",  64'(free), 64'(DEPTH));
        rst = 1'b1;

        foreach (vq[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vq[i].push, vq[i].pop, vq[i].flush, vq[i].flush, vq[i].rob);
            cyc(nm);
            chk({nm, " exp_valid"}, 64'(dvld), 64'(vq[i].evld));
            chk({nm, " exp_free"},  64'(free), 64'(vq[i].efree));
            chk({nm, " exp_full"},  64'(full), 64'(vq[i].efull));
            if (vq[i].evld) chk({nm, " exp_rob"}, 64'(dout.rob_id), 64'(vq[i].erob));
        end

        // Streaming one-in/one-out across pointer wraps.
        drive(1, 0, 0, 0, 7'd0);
        cyc("stream prime");
        chk("stream head0", 64'(dout.rob_id), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1, 0, 0, 7'(i));
            cyc("stream");
            chk($sformatf("stream head%0d", i), 64'(dout.rob_id), 64'(i));
            chk("stream free", 64'(free), 64'd3);
        end
        drive(0, 1, 0, 0, 0);
        cyc("stream drain");
        chk("stream empty", 64'(dvld), 64'd0);

        // Asynchronous reset between clock edges.
        drive(1, 0, 0, 0, 7'd20);
        cyc("arst fill0");
        drive(1, 0, 0, 0, 7'd21);
        cyc("arst fill1");
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst valid", 64'(dvld), 64'd0);
        chk("arst free",  64'(free), 64'(DEPTH));
        chk("arst full",  64'(full), 64'd0);
        mq.delete();
        #2 rst = 1'b1;
        drive(1, 0, 0, 0, 7'd22);
        cyc("arst after");
        chk("arst after rob",  64'(dout.rob_id), 64'd22);
        chk("arst after free", 64'(free), 64'd3);

        // Random traffic against the list model, including pushes while full.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
                  1'($urandom), 1'($urandom_range(0, 15) == 0), 7'($urandom));
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
